// File: rtl/pb_tile_pwr_sequencer.sv
// pb_tile_pwr_sequencer
//   Staggered clock-enable / reset sequencer for picobello tiles. A request names a set of
//   tiles and a direction; tiles are handled one at a time, lowest index first.
//   Power-up: clk_en rises, then rst_n is released ClkSettleCycles later.
//   Power-down: rst_n asserts, then clk_en drops ClkSettleCycles later.
//   Between tiles there is a gap so that inrush from consecutive tiles does not overlap.
//
// Optional feature: define PB_TILE_SEQ_ABORT_EN to add abort_i. The tile in flight always
// completes its full sequence (including the gap) before the remaining tiles are dropped.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   abort_i      (PB_TILE_SEQ_ABORT_EN only) drop remaining tiles after the current one
//   req_valid_i  request valid
//   req_ready_o  request accepted on valid && ready; high only when idle
//   req_on_i     1 = power-up, 0 = power-down
//   req_mask_i   tiles to sequence
//   clk_en_o     tile clock enables
//   rst_n_o      tile resets, active-low
//   busy_o       sequencer not idle
//   done_o       one-cycle pulse when a sequence completes
//   cur_tile_o   index of the tile being sequenced, 0 when idle
module pb_tile_pwr_sequencer #(
  parameter int unsigned NumTiles        = 16,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned GapCycles       = 2,
  localparam int unsigned TileW          = (NumTiles > 1) ? $clog2(NumTiles) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef PB_TILE_SEQ_ABORT_EN
  input  logic                abort_i,
`endif
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_on_i,
  input  logic [NumTiles-1:0] req_mask_i,
  output logic [NumTiles-1:0] clk_en_o,
  output logic [NumTiles-1:0] rst_n_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [TileW-1:0]    cur_tile_o
);

  localparam int unsigned MaxDly = (ClkSettleCycles > GapCycles) ? ClkSettleCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(MaxDly + 1);

  // Outputs are written on the edge that enters ACT1/ACT2, so the counter loads one less than
  // the delay. GAP is entered after ACT2, hence two less for the gap.
  localparam logic [CntW-1:0] SettleLoad = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] GapLoad    = CntW'((GapCycles > 1) ? (GapCycles - 2) : 0);

  typedef enum logic [2:0] {
    StIdle, StSelect, StAct1, StWait1, StAct2, StGap, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [NumTiles-1:0] pending_q, pending_d;
  logic [NumTiles-1:0] clk_en_q, clk_en_d;
  logic [NumTiles-1:0] rst_n_q, rst_n_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TileW-1:0]    cur_q, cur_d;
  logic                dir_q, dir_d;
  logic                abort_q, abort_d;
  logic                abort;
  logic [TileW-1:0]    lowest;

`ifdef PB_TILE_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Lowest set pending bit; descending scan so the lowest index wins.
  always_comb begin
    lowest = '0;
    for (int i = int'(NumTiles) - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = TileW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    dir_d     = dir_q;
    abort_d   = abort_q;
    unique case (state_q)
      StIdle: begin
        cur_d   = '0;
        abort_d = 1'b0;
        if (req_valid_i) begin
          pending_d = req_mask_i;
          dir_d     = req_on_i;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (abort || (pending_q == '0)) begin
          pending_d = '0;
          state_d   = StDone;
        end else begin
          cur_d = lowest;
          cnt_d = SettleLoad;
          if (dir_q) clk_en_d[lowest] = 1'b1;
          else       rst_n_d[lowest]  = 1'b0;
          state_d = StAct1;
        end
      end
      StAct1, StWait1: begin
        if (abort) abort_d = 1'b1;
        if (cnt_q == '0) begin
          if (dir_q) rst_n_d[cur_q]  = 1'b1;
          else       clk_en_d[cur_q] = 1'b0;
          pending_d[cur_q] = 1'b0;
          state_d          = StAct2;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWait1;
        end
      end
      StAct2: begin
        if (abort) abort_d = 1'b1;
        if (GapCycles > 1) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end else begin
          if (abort || abort_q) pending_d = '0;
          state_d = StSelect;
        end
      end
      StGap: begin
        if (abort) abort_d = 1'b1;
        if (cnt_q == '0) begin
          // An abort seen anywhere during this tile drops the rest only after its gap.
          if (abort || abort_q) pending_d = '0;
          state_d = StSelect;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        cur_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      clk_en_q  <= '1;
      rst_n_q   <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      abort_q   <= abort_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign clk_en_o    = clk_en_q;
  assign rst_n_o     = rst_n_q;
  assign cur_tile_o  = cur_q;

endmodule

// File: tb/tb_pb_tile_pwr_sequencer.sv
// Bench for pb_tile_pwr_sequencer (default build, no abort port).
// Cycle 0 is the cycle in which the request is accepted. For the k-th selected tile (ascending
// index) the first action is visible from cycle 2 + k*P and the second from S cycles later,
// with P = S + G + 1; done_o is high in cycle 2 + n*P.
module tb_pb_tile_pwr_sequencer;
  localparam int N = 16;
  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G + 1;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_on_i;
  logic [N-1:0] req_mask_i;
  logic [N-1:0] clk_en_o;
  logic [N-1:0] rst_n_o;
  logic         busy_o;
  logic         done_o;
  logic [3:0]   cur_tile_o;

  pb_tile_pwr_sequencer #(
    .NumTiles       (N),
    .ClkSettleCycles(S),
    .GapCycles      (G)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_on_i   (req_on_i),
    .req_mask_i (req_mask_i),
    .clk_en_o   (clk_en_o),
    .rst_n_o    (rst_n_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cur_tile_o (cur_tile_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state of every tile's outputs between sequences.
  logic [N-1:0] m_clk;
  logic [N-1:0] m_rst;

  typedef struct {
    bit           on;
    logic [N-1:0] mask;
    int           exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request and check every cycle until done_o against the schedule model.
  // With hold set, req_valid_i stays high carrying the next request while busy.
  task automatic run_seq(input bit on, input logic [N-1:0] mask, input int exp_done,
                         input bit hold, input bit n_on, input logic [N-1:0] n_mask);
    int           tiles[$];
    int           w;
    int           dc;
    int           seen;
    logic [N-1:0] ec;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) if (mask[i]) tiles.push_back(i);
    dc = 2 + tiles.size() * P;
    req_on_i    = on;
    req_mask_i  = mask;
    req_valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("accept_idle", {req_ready_o, busy_o, done_o, cur_tile_o}, {3'b100, 4'd0});
    @(posedge clk);
    #1;
    if (hold) begin
      req_on_i   = n_on;
      req_mask_i = n_mask;
    end else begin
      req_valid_i = 1'b0;
    end
    seen = -1;
    ec   = m_clk;
    er   = m_rst;
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      ec = m_clk;
      er = m_rst;
      foreach (tiles[j]) begin
        int a1;
        int a2;
        int t;
        a1 = 2 + j * P;
        a2 = a1 + S;
        t  = tiles[j];
        if (on) begin
          if (c >= a1) ec[t] = 1'b1;
          if (c >= a2) er[t] = 1'b1;
        end else begin
          if (c >= a1) er[t] = 1'b0;
          if (c >= a2) ec[t] = 1'b0;
        end
        if (c >= a1 && c <= a2) check($sformatf("cur_tile c%0d", c), 64'(cur_tile_o), 64'(t));
      end
      check($sformatf("outputs c%0d", c), {clk_en_o, rst_n_o, done_o, busy_o, req_ready_o},
            {ec, er, (c == dc), 1'b1, 1'b0});
      if (done_o && seen < 0) seen = c;
    end
    check("done_cycle", 64'(seen), 64'(exp_done));
    m_clk = ec;
    m_rst = er;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_wait1();
    int w;
    req_on_i    = 1'b1;
    req_mask_i  = 16'h0010;
    req_valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    // Now in cycle 4, inside the settle wait of tile 4.
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_reset_outs", {clk_en_o, rst_n_o, req_ready_o, busy_o, done_o, cur_tile_o},
          {16'hFFFF, 16'h0000, 3'b100, 4'd0});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("mid_reset_quiet %0d", i), {rst_n_o, done_o, busy_o}, {16'h0000, 2'b00});
    end
    m_clk = '1;
    m_rst = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] rmask;
    bit           ron;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_on_i    = 1'b0;
    req_mask_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", {clk_en_o, rst_n_o, req_ready_o, busy_o, done_o, cur_tile_o},
          {16'hFFFF, 16'h0000, 3'b100, 4'd0});
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    m_clk = '1;
    m_rst = '0;

    vecs[0] = '{on: 1'b1, mask: 16'h0005, exp_done: 16};
    vecs[1] = '{on: 1'b1, mask: 16'hFFFF, exp_done: 114};
    vecs[2] = '{on: 1'b0, mask: 16'h8000, exp_done: 9};
    vecs[3] = '{on: 1'b1, mask: 16'h0000, exp_done: 2};
    vecs[4] = '{on: 1'b0, mask: 16'h00F0, exp_done: 30};
    vecs[5] = '{on: 1'b1, mask: 16'h8001, exp_done: 16};
    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].on, vecs[i].mask, vecs[i].exp_done, 1'b0, 1'b0, '0);
    end

    // Second request held high while busy: must wait for idle, then run normally.
    run_seq(1'b0, 16'h0300, 16, 1'b1, 1'b0, 16'h0100);
    run_seq(1'b0, 16'h0100, 9, 1'b0, 1'b0, '0);

    reset_mid_wait1();
    run_seq(1'b1, 16'h0010, 9, 1'b0, 1'b0, '0);

    for (int k = 0; k < 20; k++) begin
      rmask = N'($urandom & $urandom & $urandom);
      ron   = 1'($urandom_range(1, 0));
      run_seq(ron, rmask, 2 + $countones(rmask) * P, 1'b0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
